ioexp_input_debounce: RTL and testbench
=======================================

// Module: ioexp_input_debounce
// PURPOSE
//  Input-conditioning stage directly upstream of the SMBus IO-expander register block.
//  Synchronises 16 raw board-level status pins into iClk and debounces each bit against the 1 ms timebase.
//  Presents stable P0/P1 bytes that feed the expander's input ports (iI0/iI1).
//  Contact bounce and sub-threshold glitches therefore never raise the expander's interrupt.
// PARAMETERS
//  SYNC_STAGES  2        synchroniser flops per bit; legal range 2..4
//  DEBOUNCE_MS  4        consecutive 1 ms ticks a new level must persist; 0 = bypass
//  RESET_VAL    16'hFFFF stable value driven during and after reset (pull-up idle)
// PORTS
//  iClk        in   1   system clock
//  iRst        in   1   synchronous reset, active-high
//  iClk_1ms    in   1   1 ms square-wave timebase, asynchronous to iClk
//  iRaw        in   16  raw pins; [15:8] -> port 0, [7:0] -> port 1
//  oI0         out  8   debounced port 0 (stable[15:8])
//  oI1         out  8   debounced port 1 (stable[7:0])
//  oChange     out  1   1-cycle pulse: at least one stable bit updated
//  oBusy       out  1   at least one bit is pending (counter non-zero)
// BEHAVIOUR
//  - Reset: all iClk edges with iRst=1 clear the state.
//      sync chain = RESET_VAL; stable = RESET_VAL; counters = 0; oChange = 0; oBusy = 0.
//  - Tick generation: iClk_1ms passes through a 2-flop synchroniser plus a delay flop.
//      tick = rising edge, high for exactly 1 iClk cycle per ms.
//  - Per bit, s = synchronised sample:
//      s == stable           -> cnt <= 0
//      s != stable, tick=0   -> cnt holds
//      s != stable, tick=1   -> cnt <= cnt + 1
//                               when cnt+1 == DEBOUNCE_MS: stable <= s, cnt <= 0
//  - Counter width = $clog2(DEBOUNCE_MS+1); cnt never exceeds DEBOUNCE_MS, no wrap.
//  - Simultaneous tick and s returning to stable in the same cycle: clear wins, no update.
//  - Latency: SYNC_STAGES cycles to sample, then DEBOUNCE_MS ticks.
//      Acceptance 1st-tick phase is arbitrary, so accept time is (DEBOUNCE_MS-1, DEBOUNCE_MS] ms.
//  - oChange: registered OR of per-bit update strobes, asserted the cycle after stable changes.
//      Multiple bits updating together produce one pulse.
//  - oBusy: registered OR of (cnt != 0).
//  - DEBOUNCE_MS == 0: stable <= s every cycle; oChange pulses on any difference; oBusy tied 0.
//  - Reset mid-debounce: pending counts are discarded.
//      The pin must re-qualify a full DEBOUNCE_MS after reset release.
//  - oI0/oI1 are flop outputs; they never glitch combinationally.
// CONFIGURATION
//  IOEXP_GLITCH_LOG_EN defined: adds outputs oGlitch[15:0] and oGlitchCnt[7:0], plus input iGlitchClr.
//    A glitch is a bit whose cnt != 0 and whose s returns to stable before acceptance.
//    oGlitch[b] is sticky-set on a glitch of bit b.
//    oGlitchCnt increments by 1 per cycle with any glitch and saturates at 8'hFF.
//    iGlitchClr clears both; a set in the same cycle as iGlitchClr wins.
//    Both reset to 0.
//  IOEXP_GLITCH_LOG_EN undefined: these ports and their logic are absent; core behaviour is identical.
// STRUCTURE
//  Package ioexp_pkg holds:
//    IOEXP_W = 16, IOEXP_PORT_W = 8, IOEXP_IDLE = 16'hFFFF (RESET_VAL default),
//    and the port-0/port-1 bit-slice constants shared with the register block.
//  Sub-module ioexp_debounce_bit: one synchroniser + counter + stable flop per bit.
//    Ports: clk, rst, tick, raw -> stable, upd, pend, glitch.
//    Instantiated 16x by generate.
//  Tick synchroniser/edge detect, oChange/oBusy reduction and the glitch log live in the top.
// TESTING
//  1 Reset with iRaw=16'h0000 -> oI0/oI1 = 8'hFF, oChange=0.
//    After release, 4 ticks -> 8'h00/8'h00 and one oChange pulse.
//  2 iRaw[15] 1->0 held 3.5 ms (DEBOUNCE_MS=4) then back to 1 -> oI0 stays 8'hFF, no oChange.
//    With IOEXP_GLITCH_LOG_EN: oGlitch=16'h8000, oGlitchCnt=1.
//  3 iRaw[3] 1->0 held 10 ms -> oI1 = 8'hF7 between 3 and 4 ms plus SYNC_STAGES+3 cycles.
//    Exactly one oChange; oBusy high only during qualification.
//  4 iRaw 16'hFFFF->16'h0F0F in one cycle -> both ports update on the same cycle.
//    Single oChange pulse; oI0=8'h0F, oI1=8'h0F.
//  5 Bit pending at cnt=3 when iRst pulses for 1 cycle -> outputs = RESET_VAL, cnt=0.
//    Re-acceptance takes a full 4 ticks after release.
//  6 s returns to stable on the exact tick cycle with cnt=3 -> no update, cnt=0, glitch logged.

Source files
------------

// File: rtl/ioexp_pkg.sv
// Shared widths, idle value and port slicing for the IO-expander input path.
package ioexp_pkg;

    localparam int unsigned IOEXP_W      = 16;
    localparam int unsigned IOEXP_PORT_W = 8;
    localparam int unsigned GLITCH_CNT_W = 8;

    // Pins idle high through board pull-ups
    localparam logic [IOEXP_W-1:0] IOEXP_IDLE = 16'hFFFF;

    // Bit slices shared with the register block: [15:8] -> port 0, [7:0] -> port 1
    localparam int unsigned IOEXP_P0_MSB = 15;
    localparam int unsigned IOEXP_P0_LSB = 8;
    localparam int unsigned IOEXP_P1_MSB = 7;
    localparam int unsigned IOEXP_P1_LSB = 0;

    typedef struct packed {
        logic [IOEXP_PORT_W-1:0] p0;
        logic [IOEXP_PORT_W-1:0] p1;
    } ioexp_ports_t;

    // Saturating increment for the glitch event counter
    function automatic logic [GLITCH_CNT_W-1:0] sat_inc(input logic [GLITCH_CNT_W-1:0] v);
        return (&v) ? v : v + GLITCH_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ioexp_debounce_bit.sv
// One input pin: synchroniser chain, tick-qualified persistence counter and stable flop.
module ioexp_debounce_bit #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE_MS = 4,
    parameter logic        RESET_BIT   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic stable,
    output logic upd,
    output logic pend,
    output logic glitch
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Bring the raw pin into clk, idling at the reset level
    always_ff @(posedge clk) begin
        if (rst) sync_q <= {SYNC_STAGES{RESET_BIT}};
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end

    if (DEBOUNCE_MS == 0) begin : g_bypass
        logic tick_unused;
        assign tick_unused = tick;
        assign pend        = 1'b0;
        assign glitch      = 1'b0;

        // No filtering: follow the synchronised sample every cycle
        always_ff @(posedge clk) begin
            if (rst) begin
                stable <= RESET_BIT;
                upd    <= 1'b0;
            end else begin
                stable <= s;
                upd    <= (s != stable);
            end
        end
    end else begin : g_debounce
        localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_MS + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS);

        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_inc;
        logic             accept;

        assign cnt_inc = cnt_q + CNT_W'(1);
        assign accept  = (s != stable) && tick && (cnt_inc == CNT_LAST);
        assign pend    = (cnt_q != '0);
        // Sample fell back to the stable level while a count was running
        assign glitch  = pend && (s == stable);

        // Count ticks while the sample differs; a return to stable always clears
        always_ff @(posedge clk) begin
            if (rst) begin
                stable <= RESET_BIT;
                cnt_q  <= '0;
                upd    <= 1'b0;
            end else begin
                upd <= accept;
                if (s == stable) begin
                    cnt_q <= '0;
                end else if (tick) begin
                    if (accept) begin
                        stable <= s;
                        cnt_q  <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ioexp_input_debounce.sv
// 16-pin synchroniser/debouncer feeding the IO-expander input ports.
// Optional glitch log enabled by defining IOEXP_GLITCH_LOG_EN.
module ioexp_input_debounce
    import ioexp_pkg::*;
#(
    parameter int unsigned        SYNC_STAGES = 2,
    parameter int unsigned        DEBOUNCE_MS = 4,
    parameter logic [IOEXP_W-1:0] RESET_VAL   = IOEXP_IDLE
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iClk_1ms,
    input  logic [IOEXP_W-1:0]      iRaw,
    output logic [IOEXP_PORT_W-1:0] oI0,
    output logic [IOEXP_PORT_W-1:0] oI1,
    output logic                    oChange,
    output logic                    oBusy
`ifdef IOEXP_GLITCH_LOG_EN
    ,
    input  logic                    iGlitchClr,
    output logic [IOEXP_W-1:0]      oGlitch,
    output logic [GLITCH_CNT_W-1:0] oGlitchCnt
`endif
);

    logic [1:0]         tsync_q;
    logic               tdly_q;
    logic               tick_c;
    logic [IOEXP_W-1:0] stable_vec;
    logic [IOEXP_W-1:0] upd_vec;
    logic [IOEXP_W-1:0] pend_vec;
    logic [IOEXP_W-1:0] glitch_vec;
    ioexp_ports_t       ports;

    // Synchronise the 1 ms timebase and keep a delayed copy for edge detection
    always_ff @(posedge iClk) begin
        if (iRst) begin
            tsync_q <= '0;
            tdly_q  <= 1'b0;
        end else begin
            tsync_q <= {tsync_q[0], iClk_1ms};
            tdly_q  <= tsync_q[1];
        end
    end

    assign tick_c = tsync_q[1] & ~tdly_q;

    for (genvar b = 0; b < IOEXP_W; b++) begin : g_bit
        ioexp_debounce_bit #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE_MS(DEBOUNCE_MS),
            .RESET_BIT  (RESET_VAL[b])
        ) u_bit (
            .clk   (iClk),
            .rst   (iRst),
            .tick  (tick_c),
            .raw   (iRaw[b]),
            .stable(stable_vec[b]),
            .upd   (upd_vec[b]),
            .pend  (pend_vec[b]),
            .glitch(glitch_vec[b])
        );
    end

    // Stable bits are flops inside each bit slice; this is only wiring
    assign ports = ioexp_ports_t'(stable_vec);
    assign oI0   = ports.p0;
    assign oI1   = ports.p1;

    // Collapse per-bit strobes into single status flags
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oChange <= 1'b0;
            oBusy   <= 1'b0;
        end else begin
            oChange <= |upd_vec;
            oBusy   <= |pend_vec;
        end
    end

`ifdef IOEXP_GLITCH_LOG_EN
    // Sticky per-bit glitch flags and saturating event count; new events beat clear
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oGlitch    <= '0;
            oGlitchCnt <= '0;
        end else if (iGlitchClr) begin
            oGlitch    <= glitch_vec;
            oGlitchCnt <= GLITCH_CNT_W'(|glitch_vec);
        end else begin
            oGlitch <= oGlitch | glitch_vec;
            if (|glitch_vec) oGlitchCnt <= sat_inc(oGlitchCnt);
        end
    end
`else
    logic glitch_unused;
    assign glitch_unused = |glitch_vec;
`endif

endmodule

// File: tb/tb_ioexp_input_debounce.sv
// Directed bench for ioexp_input_debounce (SYNC_STAGES=2, DEBOUNCE_MS=4, 1 ms = 20 clocks).
module tb_ioexp_input_debounce;
    import ioexp_pkg::*;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iClk_1ms;
    logic [15:0] iRaw;
    logic [7:0]  oI0;
    logic [7:0]  oI1;
    logic        oChange;
    logic        oBusy;
`ifdef IOEXP_GLITCH_LOG_EN
    logic        iGlitchClr;
    logic [15:0] oGlitch;
    logic [7:0]  oGlitchCnt;
`endif

    int checks = 0;
    int errors = 0;
    int chg_total = 0;
    int start;

    typedef struct {
        logic [15:0] raw;
        int          ticks;
        logic [7:0]  i0;
        logic [7:0]  i1;
        int          changes;
        logic        busy;
    } vec_t;

    vec_t vecs[10];

    ioexp_input_debounce dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iClk_1ms  (iClk_1ms),
        .iRaw      (iRaw),
        .oI0       (oI0),
        .oI1       (oI1),
        .oChange   (oChange),
        .oBusy     (oBusy)
`ifdef IOEXP_GLITCH_LOG_EN
        ,
        .iGlitchClr(iGlitchClr),
        .oGlitch   (oGlitch),
        .oGlitchCnt(oGlitchCnt)
`endif
    );

    always #5 iClk = ~iClk;

    // Count oChange pulses, sampled 2 units after the active edge
    always begin
        @(posedge iClk);
        #2;
        if (oChange) chg_total++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // One full 1 ms period starting at a negedge: 10 clocks high, 10 low
    task automatic ms_period();
        iClk_1ms = 1'b1;
        repeat (10) @(negedge iClk);
        iClk_1ms = 1'b0;
        repeat (10) @(negedge iClk);
    endtask

    task automatic settle_to(input logic [15:0] raw);
        iRaw = raw;
        repeat (4) @(negedge iClk);
        repeat (4) ms_period();
        repeat (8) @(negedge iClk);
    endtask

    initial begin
        // raw, ticks, i0, i1, changes, busy
        vecs[0] = '{16'h0000, 4, 8'h00, 8'h00, 1, 1'b0};
        vecs[1] = '{16'hFFFF, 3, 8'h00, 8'h00, 0, 1'b1};
        vecs[2] = '{16'h0000, 2, 8'h00, 8'h00, 0, 1'b0};
        vecs[3] = '{16'hFFFF, 4, 8'hFF, 8'hFF, 1, 1'b0};
        vecs[4] = '{16'h0F0F, 4, 8'h0F, 8'h0F, 1, 1'b0};
        vecs[5] = '{16'h7FFF, 3, 8'h0F, 8'h0F, 0, 1'b1};
        vecs[6] = '{16'h7FFF, 1, 8'h7F, 8'hFF, 1, 1'b0};
        vecs[7] = '{16'hFFF7, 4, 8'hFF, 8'hF7, 1, 1'b0};
        vecs[8] = '{16'hFFF7, 0, 8'hFF, 8'hF7, 0, 1'b0};
        vecs[9] = '{16'hA55A, 4, 8'hA5, 8'h5A, 1, 1'b0};

        iRst = 1'b1;
        iRaw = 16'h0000;
        iClk_1ms = 1'b0;
`ifdef IOEXP_GLITCH_LOG_EN
        iGlitchClr = 1'b0;
`endif
        repeat (3) @(negedge iClk);

        // Reset holds the idle value even with all pins low
        check("rst_i0", 16'(oI0), 16'h00FF);
        check("rst_i1", 16'(oI1), 16'h00FF);
        check("rst_change", 16'(oChange), 16'h0);
        check("rst_busy", 16'(oBusy), 16'h0);
`ifdef IOEXP_GLITCH_LOG_EN
        check("rst_glitch", oGlitch, 16'h0000);
        check("rst_gcnt", 16'(oGlitchCnt), 16'h0);
`endif
        iRst = 1'b0;

        // Table of level changes with tick counts
        for (int i = 0; i < 10; i++) begin
            iRaw  = vecs[i].raw;
            start = chg_total;
            repeat (4) @(negedge iClk);
            for (int t = 0; t < vecs[i].ticks; t++) ms_period();
            repeat (8) @(negedge iClk);
            check($sformatf("v%0d_i0", i), 16'(oI0), 16'(vecs[i].i0));
            check($sformatf("v%0d_i1", i), 16'(oI1), 16'(vecs[i].i1));
            check($sformatf("v%0d_chg", i), 16'(chg_total - start), 16'(vecs[i].changes));
            check($sformatf("v%0d_busy", i), 16'(oBusy), 16'(vecs[i].busy));
        end

        // Exact acceptance timing on the 4th tick
        settle_to(16'hFFFF);
        iRaw = 16'hFFF7;
        repeat (4) @(negedge iClk);
        repeat (3) ms_period();
        check("lat_pre_i1", 16'(oI1), 16'h00FF);
        check("lat_pre_busy", 16'(oBusy), 16'h1);
        start = chg_total;
        iClk_1ms = 1'b1;
        @(negedge iClk);
        check("lat_c1_i1", 16'(oI1), 16'h00FF);
        @(negedge iClk);
        check("lat_c2_i1", 16'(oI1), 16'h00FF);
        @(negedge iClk);
        check("lat_c3_i1", 16'(oI1), 16'h00F7);
        check("lat_c3_chg", 16'(oChange), 16'h0);
        check("lat_c3_busy", 16'(oBusy), 16'h1);
        @(negedge iClk);
        check("lat_c4_chg", 16'(oChange), 16'h1);
        check("lat_c4_busy", 16'(oBusy), 16'h0);
        @(negedge iClk);
        check("lat_c5_chg", 16'(oChange), 16'h0);
        repeat (5) @(negedge iClk);
        iClk_1ms = 1'b0;
        repeat (10) @(negedge iClk);
        repeat (6) ms_period();
        check("lat_hold_chg", 16'(chg_total - start), 16'h1);
        check("lat_hold_i0", 16'(oI0), 16'h00FF);

        // 3.5 ms low pulse on bit 15 is rejected
        settle_to(16'hFFFF);
`ifdef IOEXP_GLITCH_LOG_EN
        iGlitchClr = 1'b1;
        @(negedge iClk);
        iGlitchClr = 1'b0;
`endif
        start = chg_total;
        iRaw = 16'h7FFF;
        repeat (4) @(negedge iClk);
        repeat (3) ms_period();
        repeat (10) @(negedge iClk);
        iRaw = 16'hFFFF;
        repeat (10) @(negedge iClk);
        repeat (2) ms_period();
        check("gl_i0", 16'(oI0), 16'h00FF);
        check("gl_chg", 16'(chg_total - start), 16'h0);
        check("gl_busy", 16'(oBusy), 16'h0);
`ifdef IOEXP_GLITCH_LOG_EN
        check("gl_flags", oGlitch, 16'h8000);
        check("gl_cnt", 16'(oGlitchCnt), 16'h1);
        iGlitchClr = 1'b1;
        @(negedge iClk);
        iGlitchClr = 1'b0;
`endif

        // Sample returns to stable on the very tick that would accept: clear wins
        start = chg_total;
        iRaw = 16'hFFFE;
        repeat (4) @(negedge iClk);
        repeat (3) ms_period();
        check("clr_pre_busy", 16'(oBusy), 16'h1);
        iRaw = 16'hFFFF;
        ms_period();
        repeat (4) @(negedge iClk);
        check("clr_i1", 16'(oI1), 16'h00FF);
        check("clr_busy", 16'(oBusy), 16'h0);
        check("clr_chg", 16'(chg_total - start), 16'h0);
`ifdef IOEXP_GLITCH_LOG_EN
        check("clr_flags", oGlitch, 16'h0001);
        check("clr_gcnt", 16'(oGlitchCnt), 16'h1);
`endif
        iRaw = 16'hFFFE;
        repeat (4) @(negedge iClk);
        repeat (3) ms_period();
        check("clr_req3_i1", 16'(oI1), 16'h00FF);
        ms_period();
        check("clr_req4_i1", 16'(oI1), 16'h00FE);

        // Reset in the middle of qualification discards the count
        settle_to(16'hFFFF);
        iRaw = 16'hFFFE;
        repeat (4) @(negedge iClk);
        repeat (3) ms_period();
        check("mid_pre_busy", 16'(oBusy), 16'h1);
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        check("mid_rst_i1", 16'(oI1), 16'h00FF);
        check("mid_rst_busy", 16'(oBusy), 16'h0);
        start = chg_total;
        repeat (4) @(negedge iClk);
        repeat (3) ms_period();
        check("mid_3t_i1", 16'(oI1), 16'h00FF);
        ms_period();
        check("mid_4t_i1", 16'(oI1), 16'h00FE);
        check("mid_4t_chg", 16'(chg_total - start), 16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
